// File: rtl/axis_frame_receiver_if.sv
// Bundles the AXI4-Stream pixel input, the framebuffer write port and the
// frame status outputs of axis_frame_receiver.
//   slave  : receiver side (consumes the stream, drives writes and status)
//   master : environment side (produces the stream, accepts writes)
interface axis_frame_receiver_if #(
    parameter int ADDR_W = 9
);
    logic [31:0]       s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready;
    logic              frame_done;
    logic              err_early_last;
    logic              err_missing_last;
    logic [15:0]       frame_count;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, wr_ready,
        output s_axis_tready, wr_en, wr_addr, wr_data,
               frame_done, err_early_last, err_missing_last, frame_count
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, wr_ready,
        input  s_axis_tready, wr_en, wr_addr, wr_data,
               frame_done, err_early_last, err_missing_last, frame_count
    );
endinterface

// File: rtl/axis_frame_receiver.sv
// Receives a raster-ordered pixel stream and turns each accepted beat into a
// single framebuffer write at linear address y*WIDTH+x. Flags frames whose
// tlast does not line up with the final pixel position.
// Ports:
//   aclk    : clock
//   areset  : asynchronous active-high reset
//   bus     : stream input, write request port and status (slave modport)
//
// state | meaning
// IDLE  | one cycle after reset before accepting pixels
// RECV  | accepting pixels, issuing writes
// DRAIN | frame complete, waiting for the last write to be taken
module axis_frame_receiver #(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 20,
    parameter int ADDR_W = 9
) (
    input logic                   aclk,
    input logic                   areset,
    axis_frame_receiver_if.slave  bus
);
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [XW-1:0]     LAST_X   = XW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              err_early_q, err_early_d;
    logic              err_missing_q, err_missing_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic tready;
    logic accept;
    logic last_pos;

    always_comb begin
        // Ready only when the output register is free or being emptied this
        // cycle, which lets a new beat replace a completing write.
        tready   = (state_q == RECV) && (!wr_en_q || bus.wr_ready);
        accept   = bus.s_axis_tvalid && tready;
        last_pos = (idx_q == LAST_IDX);

        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        idx_d         = idx_q;
        wr_en_d       = wr_en_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        err_early_d   = 1'b0;
        err_missing_d = 1'b0;
        frame_count_d = frame_count_q;

        if (wr_en_q && bus.wr_ready) begin
            wr_en_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = RECV;
            end
            RECV: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = bus.s_axis_tdata;
                    if (last_pos || bus.s_axis_tlast) begin
                        // Frame end or early tlast: either way restart the
                        // raster so the next beat lands at address 0.
                        x_d           = '0;
                        y_d           = '0;
                        idx_d         = '0;
                        err_missing_d = last_pos && !bus.s_axis_tlast;
                        err_early_d   = !last_pos && bus.s_axis_tlast;
                        if (last_pos) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                        if (x_q == LAST_X) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!wr_en_q) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            idx_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            idx_q         <= idx_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.s_axis_tready    = tready;
    assign bus.wr_en            = wr_en_q;
    assign bus.wr_addr          = wr_addr_q;
    assign bus.wr_data          = wr_data_q;
    assign bus.frame_done       = frame_done_q;
    assign bus.err_early_last   = err_early_q;
    assign bus.err_missing_last = err_missing_q;
    assign bus.frame_count      = frame_count_q;
endmodule

// File: doc/axis_frame_receiver.md
AXIS_FRAME_RECEIVER -- requirements
Module: axis_frame_receiver

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH, default 20, SHALL be the pixels per line.
REQ-003 Parameter HEIGHT, default 20, SHALL be the lines per frame.
REQ-004 Parameter ADDR_W, default 9, SHALL be the write address width and SHALL satisfy 2**ADDR_W >= WIDTH*HEIGHT.
REQ-005 aclk  in  1  SHALL be the clock for all state; all state changes on its rising edge.
REQ-006 areset  in  1  SHALL be the asynchronous active-high reset.
REQ-007 s_axis_tdata  in  32  SHALL carry the AXI4-Stream slave pixel data.
REQ-008 s_axis_tvalid  in  1  SHALL be the slave beat-valid input.
REQ-009 s_axis_tready  out  1  SHALL be the slave ready output.
REQ-010 s_axis_tlast  in  1  SHALL mark the last pixel of a frame.
REQ-011 wr_en  out  1  SHALL mark a pending framebuffer write request.
REQ-012 wr_addr  out  ADDR_W  SHALL be the linear pixel address, y*WIDTH+x.
REQ-013 wr_data  out  32  SHALL be the pixel to write.
REQ-014 wr_ready  in  1  SHALL be the sink accept input; a write completes when wr_en && wr_ready.
REQ-015 frame_done  out  1  SHALL be a one-cycle pulse when a frame has been fully written.
REQ-016 err_early_last  out  1  SHALL be a one-cycle pulse when tlast arrives before the final pixel position.
REQ-017 err_missing_last  out  1  SHALL be a one-cycle pulse when the final pixel position arrives without tlast.
REQ-018 frame_count  out  16  SHALL count completed frames, wrapping 0xFFFF->0.

Function
REQ-019 The FSM SHALL have states IDLE, RECV and DRAIN.
REQ-020 IDLE SHALL transition to RECV unconditionally after one cycle.
REQ-021 s_axis_tready SHALL equal (!wr_en || wr_ready) in RECV and 0 in IDLE and DRAIN.
REQ-022 A beat SHALL be accepted only when s_axis_tvalid && s_axis_tready.
REQ-023 On accept, the block SHALL load wr_data<=tdata and wr_addr<=current linear index, and set wr_en<=1 on the next cycle, giving one cycle of latency.
REQ-024 wr_en, wr_addr and wr_data SHALL hold stable until wr_ready; wr_en SHALL clear after a completed write unless a new beat is accepted in the same cycle, giving back-to-back throughput of 1 beat/cycle.
REQ-025 Counters x (0..WIDTH-1) and y (0..HEIGHT-1) and the linear index SHALL advance on each accept; x wraps to 0 and y increments at x==WIDTH-1.
REQ-026 Last position with tlast=1 SHALL reset the counters to 0 and go to DRAIN.
REQ-027 Last position with tlast=0 SHALL pulse err_missing_last, reset the counters to 0 and go to DRAIN; the pixel is still written.
REQ-028 tlast=1 at a non-last position SHALL pulse err_early_last, write the pixel, reset the counters to 0 (resync), stay in RECV, and produce no frame_done and no frame_count increment.
REQ-029 In DRAIN, the cycle wr_en is 0 SHALL register frame_done=1 for one cycle, increment frame_count and return to RECV.
REQ-030 Error pulses SHALL be registered and asserted in the cycle after the offending accept.
REQ-031 s_axis_tdata SHALL be ignored when no accept occurs.
REQ-032 Address arithmetic SHALL use ADDR_W bits with no overflow for legal parameters.

Reset
REQ-033 During areset, state SHALL be IDLE; x, y, index, wr_en, wr_addr, wr_data, frame_done, both error outputs, frame_count and s_axis_tready SHALL all be 0.
REQ-034 areset asserted mid-frame SHALL immediately drop any pending write, and the next frame after release SHALL start at address 0.

Verification (WIDTH=4, HEIGHT=2, ADDR_W=3)
REQ-035 Stream 8 beats 0..7 with tlast on the 8th and wr_ready=1 -> writes at addr 0..7 with data 0..7 one cycle after each accept; frame_done pulses once; frame_count=1.
REQ-036 Hold wr_ready=0 for 3 cycles mid-frame -> wr_en, wr_addr and wr_data stay stable, s_axis_tready=0, and no beat is lost or duplicated.
REQ-037 tlast on beat 3 -> err_early_last pulses, the next beat writes addr 0, and frame_count is unchanged.
REQ-038 8 beats with no tlast -> err_missing_last pulses after beat 8, frame_done still pulses, and beat 9 writes addr 0.
REQ-039 Assert areset after beat 5 -> all outputs read 0 at once; after release a full frame writes addr 0..7 and frame_count=1.
REQ-040 Send 3 back-to-back frames with random tvalid/wr_ready gaps -> frame_count=3 and exactly 24 completed writes in order.
